// File: rtl/finisher_ng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | finisher_ng_pkg                                                      |
// | Shared FSM state encoding, finish codes and width helper.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package finisher_ng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INJECT    = 3'd1,
        ST_WAIT_TERM = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FINISHED  = 3'd4
    } fsm_state_e;

    typedef enum logic [1:0] {
        CODE_NONE    = 2'd0,
        CODE_DONE    = 2'd1,
        CODE_KPRINT  = 2'd2,
        CODE_TIMEOUT = 2'd3
    } finish_code_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/finisher_ng_report_change_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | report_change_arb                                                    |
// | Per-channel change detection with round-robin event emission.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module report_change_arb
    import finisher_ng_pkg::*;
#(
    parameter int NCH = 4,
    parameter int RW  = 32
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    en,
    input  logic [NCH*RW-1:0]                       report,
    output logic                                    rpt_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rpt_chan,
    output logic [RW-1:0]                           rpt_data
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0][RW-1:0] rep_w;
    logic [NCH-1:0][RW-1:0] shadow_q, shadow_d;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0]         changed;
    logic [CW-1:0]          last_q, last_d;
    logic [CW-1:0]          sel;
    logic [CW-1:0]          idx;
    logic                   sel_found;
    logic                   rpt_valid_q, rpt_valid_d;
    logic [CW-1:0]          rpt_chan_q, rpt_chan_d;
    logic [RW-1:0]          rpt_data_q, rpt_data_d;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign rep_w[k]   = report[k*RW +: RW];
        assign changed[k] = (rep_w[k] != shadow_q[k]);
    end

    // Scan starts one past the last served channel and wraps.
    always_comb begin
        sel       = last_q;
        sel_found = 1'b0;
        idx       = last_q;
        for (int i = 0; i < NCH; i++) begin
            idx = (idx == CW'(NCH - 1)) ? '0 : idx + 1'b1;
            if (!sel_found && pending_q[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    // The live report value is emitted so a change landing on an already
    // pending channel is folded into the same single event.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        last_d      = last_q;
        rpt_valid_d = 1'b0;
        rpt_chan_d  = rpt_chan_q;
        rpt_data_d  = rpt_data_q;
        for (int k = 0; k < NCH; k++) begin
            if (changed[k]) begin
                shadow_d[k]  = rep_w[k];
                pending_d[k] = 1'b1;
            end
        end
        if (en && sel_found) begin
            rpt_valid_d    = 1'b1;
            rpt_chan_d     = sel;
            rpt_data_d     = rep_w[sel];
            pending_d[sel] = 1'b0;
            last_d         = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_q    <= rep_w;
            pending_q   <= '0;
            last_q      <= CW'(NCH - 1);
            rpt_valid_q <= 1'b0;
            rpt_chan_q  <= '0;
            rpt_data_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_chan_q  <= rpt_chan_d;
            rpt_data_q  <= rpt_data_d;
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_chan  = rpt_chan_q;
    assign rpt_data  = rpt_data_q;

endmodule
`default_nettype wire

// File: rtl/finisher_ng.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | finisher_ng                                                          |
// | End-of-test sequencer: done / kprint / timeout, drain, finish.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module finisher_ng
    import finisher_ng_pkg::*;
#(
    parameter int         NCH            = 4,
    parameter int         RW             = 32,
    parameter int         KPRINT_MODE    = 0,
    parameter logic [7:0] TRIG_CHAR      = 8'h72,
    parameter logic [7:0] TERM_CHAR      = 8'h2E,
    parameter int         DRAIN_CYCLES   = 16,
    parameter int         TIMEOUT_CYCLES = 0
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NCH*RW-1:0]                       report,
    input  logic                                    done,
    input  logic                                    con_valid,
    input  logic [7:0]                              con_data,
    output logic                                    inj_valid,
    output logic [7:0]                              inj_data,
    input  logic                                    inj_ready,
    output logic                                    rpt_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rpt_chan,
    output logic [RW-1:0]                           rpt_data,
    output logic                                    finish,
    output logic [1:0]                              finish_code
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int DW = cnt_width(DRAIN_CYCLES);

    fsm_state_e   state_q, state_d;
    finish_code_e code_q, code_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          timeout_hit;
    logic          drain_last;
    logic          term_seen;
    logic          arb_en;

    // Saturating counter; the hit stays asserted once reached.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q != TW'(TIMEOUT_CYCLES))) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TW'(TIMEOUT_CYCLES));
    end

    always_comb begin
        drain_cnt_d = (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
        drain_last  = (DRAIN_CYCLES <= 1) || (drain_cnt_q == DW'(DRAIN_CYCLES - 1));
        term_seen   = con_valid && (con_data == TERM_CHAR);
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (done) begin
                    if (KPRINT_MODE != 0) begin
                        state_d = ST_INJECT;
                    end else begin
                        state_d = ST_DRAIN;
                        code_d  = CODE_DONE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DRAIN;
                    code_d  = CODE_TIMEOUT;
                end
            end
            ST_INJECT: begin
                if (inj_ready) begin
                    state_d = ST_WAIT_TERM;
                end else if (timeout_hit) begin
                    state_d = ST_DRAIN;
                    code_d  = CODE_TIMEOUT;
                end
            end
            ST_WAIT_TERM: begin
                if (term_seen) begin
                    state_d = ST_DRAIN;
                    code_d  = CODE_KPRINT;
                end else if (timeout_hit) begin
                    state_d = ST_DRAIN;
                    code_d  = CODE_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_d = ST_FINISHED;
                end
            end
            ST_FINISHED: begin
                state_d = ST_FINISHED;
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = CODE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            code_q      <= CODE_NONE;
            tmo_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            tmo_cnt_q   <= tmo_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign finish      = (state_q == ST_FINISHED);
    assign finish_code = code_q;
    assign inj_valid   = (state_q == ST_INJECT);
    assign inj_data    = inj_valid ? TRIG_CHAR : 8'h00;

    // Looking at the next state keeps the event registered on the entry
    // edge into FINISHED from ever becoming visible.
    assign arb_en = (state_d != ST_FINISHED);

    report_change_arb #(
        .NCH (NCH),
        .RW  (RW)
    ) u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .en        (arb_en),
        .report    (report),
        .rpt_valid (rpt_valid),
        .rpt_chan  (rpt_chan),
        .rpt_data  (rpt_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_finisher_ng.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_finisher_ng                                                       |
// | Self-checking bench: report-change model plus finish-path scenarios. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_finisher_ng;

    localparam int NCH = 4;
    localparam int RW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [RW-1:0]     rep_arr [NCH];
    logic [NCH*RW-1:0] report;
    logic              done_d, done_k, done_t;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              inj_ready;

    always_comb begin
        report = '0;
        for (int k = 0; k < NCH; k++) report[k*RW +: RW] = rep_arr[k];
    end

    logic d_inj_valid, k_inj_valid, t_inj_valid;
    logic [7:0] d_inj_data, k_inj_data, t_inj_data;
    logic d_rpt_valid, k_rpt_valid, t_rpt_valid;
    logic [1:0] d_rpt_chan, k_rpt_chan, t_rpt_chan;
    logic [RW-1:0] d_rpt_data, k_rpt_data, t_rpt_data;
    logic d_finish, k_finish, t_finish;
    logic [1:0] d_code, k_code, t_code;

    finisher_ng #(.NCH(NCH), .RW(RW), .KPRINT_MODE(0), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_direct (
        .clk(clk), .resetn(resetn), .report(report), .done(done_d),
        .con_valid(con_valid), .con_data(con_data),
        .inj_valid(d_inj_valid), .inj_data(d_inj_data), .inj_ready(inj_ready),
        .rpt_valid(d_rpt_valid), .rpt_chan(d_rpt_chan), .rpt_data(d_rpt_data),
        .finish(d_finish), .finish_code(d_code));

    finisher_ng #(.NCH(NCH), .RW(RW), .KPRINT_MODE(1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_kp (
        .clk(clk), .resetn(resetn), .report(report), .done(done_k),
        .con_valid(con_valid), .con_data(con_data),
        .inj_valid(k_inj_valid), .inj_data(k_inj_data), .inj_ready(inj_ready),
        .rpt_valid(k_rpt_valid), .rpt_chan(k_rpt_chan), .rpt_data(k_rpt_data),
        .finish(k_finish), .finish_code(k_code));

    finisher_ng #(.NCH(NCH), .RW(RW), .KPRINT_MODE(0), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .resetn(resetn), .report(report), .done(done_t),
        .con_valid(con_valid), .con_data(con_data),
        .inj_valid(t_inj_valid), .inj_data(t_inj_data), .inj_ready(inj_ready),
        .rpt_valid(t_rpt_valid), .rpt_chan(t_rpt_chan), .rpt_data(t_rpt_data),
        .finish(t_finish), .finish_code(t_code));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for dut_direct's event stream: each channel holds a
    // "needs reporting" flag; one flagged channel is served per cycle in
    // circular order after the previous one, reporting its latest value.
    logic [RW-1:0] m_val  [NCH];
    bit            m_flag [NCH];
    int            m_last;
    bit            m_en;
    bit            exp_v;
    int            exp_c;
    logic [RW-1:0] exp_d;

    int            cyc;
    int            ev_chan [$];
    logic [RW-1:0] ev_data [$];
    int            ev_cyc  [$];
    int            k_events;

    task automatic model_step();
        int sel;
        sel   = -1;
        exp_v = 1'b0;
        if (!resetn) begin
            for (int k = 0; k < NCH; k++) begin
                m_val[k]  = rep_arr[k];
                m_flag[k] = 1'b0;
            end
            m_last = NCH - 1;
            return;
        end
        if (m_en) begin
            for (int i = 1; i <= NCH; i++) begin
                if (sel < 0 && m_flag[(m_last + i) % NCH]) sel = (m_last + i) % NCH;
            end
        end
        if (sel >= 0) begin
            exp_v       = 1'b1;
            exp_c       = sel;
            exp_d       = rep_arr[sel];
            m_val[sel]  = rep_arr[sel];
            m_flag[sel] = 1'b0;
            m_last      = sel;
        end
        for (int k = 0; k < NCH; k++) begin
            if (k != sel && rep_arr[k] !== m_val[k]) begin
                m_val[k]  = rep_arr[k];
                m_flag[k] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (d_rpt_valid) begin
            ev_chan.push_back(int'(d_rpt_chan));
            ev_data.push_back(d_rpt_data);
            ev_cyc.push_back(cyc);
        end
        if (k_rpt_valid) k_events++;
        check_eq("rpt_valid", d_rpt_valid, exp_v);
        if (exp_v) begin
            check_eq("rpt_chan", d_rpt_chan, exp_c);
            check_eq("rpt_data", d_rpt_data, exp_d);
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        done_d    = 1'b0;
        done_k    = 1'b0;
        done_t    = 1'b0;
        con_valid = 1'b0;
        con_data  = 8'h00;
        inj_ready = 1'b0;
        m_en      = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    task automatic clear_log();
        ev_chan.delete();
        ev_data.delete();
        ev_cyc.delete();
    endtask

    initial begin
        cyc      = 0;
        k_events = 0;
        m_last   = NCH - 1;
        for (int k = 0; k < NCH; k++) rep_arr[k] = '0;

        // Reset state of every instance
        do_reset();
        check_eq("rst_d_finish", d_finish, 0);
        check_eq("rst_d_code", d_code, 0);
        check_eq("rst_d_rpt", {d_rpt_valid, d_rpt_chan, d_rpt_data}, 0);
        check_eq("rst_k_inj", {k_inj_valid, k_inj_data}, 0);
        check_eq("rst_k_finish", {k_finish, k_code}, 0);
        check_eq("rst_t_finish", {t_finish, t_code}, 0);

        // Timeout at cycle 100 with done never asserted
        repeat (99) tick();
        check_eq("to_code_99", t_code, 0);
        tick();
        check_eq("to_code_100", t_code, 3);
        check_eq("to_finish_100", t_finish, 0);
        repeat (3) tick();
        check_eq("to_finish_103", t_finish, 0);
        tick();
        check_eq("to_finish_104", t_finish, 1);
        check_eq("to_code_104", t_code, 3);
        check_eq("direct_idle", d_finish, 0);

        // Values present during reset must not produce events
        for (int k = 0; k < NCH; k++) rep_arr[k] = $urandom_range(1000);
        do_reset();
        clear_log();
        repeat (99) tick();
        check_eq("rst_load_no_events", ev_chan.size(), 0);
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        check_eq("to_done_same_cycle", t_code, 1);

        // Round-robin from a fresh reset
        for (int k = 0; k < NCH; k++) rep_arr[k] = '0;
        do_reset();
        clear_log();
        rep_arr[0] = 32'd11;
        rep_arr[1] = 32'd12;
        rep_arr[3] = 32'd13;
        repeat (6) tick();
        check_eq("rr_count", ev_chan.size(), 3);
        if (ev_chan.size() == 3) begin
            check_eq("rr_first", ev_chan[0], 0);
            check_eq("rr_second", ev_chan[1], 1);
            check_eq("rr_third", ev_chan[2], 3);
            check_eq("rr_consec1", ev_cyc[1], ev_cyc[0] + 1);
            check_eq("rr_consec2", ev_cyc[2], ev_cyc[1] + 1);
        end

        // Coalescing on channel 2
        clear_log();
        rep_arr[2] = 32'd5;
        tick();
        rep_arr[2] = 32'd9;
        repeat (5) tick();
        check_eq("coal_count", ev_chan.size(), 1);
        if (ev_chan.size() == 1) begin
            check_eq("coal_chan", ev_chan[0], 2);
            check_eq("coal_data", ev_data[0], 9);
        end

        // Random report traffic against the model
        repeat (300) begin
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(3) == 0) rep_arr[k] = $urandom_range(3);
            tick();
        end
        repeat (6) tick();

        // Direct finish path; an event is still expected during drain
        done_d = 1'b1;
        tick();
        done_d = 1'b0;
        check_eq("dir_code_entry", d_code, 1);
        check_eq("dir_finish_e0", d_finish, 0);
        rep_arr[0] = rep_arr[0] + 32'd1;
        repeat (3) tick();
        check_eq("dir_finish_e3", d_finish, 0);
        m_en = 1'b0;
        tick();
        check_eq("dir_finish_e4", d_finish, 1);
        rep_arr[3] = rep_arr[3] + 32'd7;
        repeat (4) tick();
        check_eq("dir_finish_sticky", d_finish, 1);
        check_eq("dir_code_frozen", d_code, 1);

        // Kprint path; console bytes before WAIT_TERM are ignored
        con_valid = 1'b1;
        con_data  = 8'h2E;
        tick();
        check_eq("kp_idle_ignore", k_code, 0);
        done_k = 1'b1;
        tick();
        done_k = 1'b0;
        repeat (3) begin
            check_eq("kp_inj_valid", k_inj_valid, 1);
            check_eq("kp_inj_data", k_inj_data, 8'h72);
            check_eq("kp_inj_ignore", k_code, 0);
            tick();
        end
        con_valid = 1'b0;
        inj_ready = 1'b1;
        check_eq("kp_inj_hold", {k_inj_valid, k_inj_data}, {1'b1, 8'h72});
        tick();
        inj_ready = 1'b0;
        check_eq("kp_inj_once", k_inj_valid, 0);
        con_valid = 1'b1;
        con_data  = 8'h61;
        tick();
        check_eq("kp_code_a", k_code, 0);
        check_eq("kp_inj_still_low", k_inj_valid, 0);
        con_data = 8'h2E;
        tick();
        con_valid = 1'b0;
        check_eq("kp_code_term", k_code, 2);
        repeat (3) tick();
        check_eq("kp_finish_e3", k_finish, 0);
        tick();
        check_eq("kp_finish_e4", k_finish, 1);
        check_eq("kp_code_final", k_code, 2);

        // Reset abort from WAIT_TERM with an event about to be emitted
        do_reset();
        done_k = 1'b1;
        tick();
        done_k    = 1'b0;
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        check_eq("ab_waitterm", k_inj_valid, 0);
        rep_arr[1] = rep_arr[1] + 32'd5;
        tick();
        resetn     = 1'b0;
        rep_arr[2] = rep_arr[2] + 32'd3;
        tick();
        check_eq("ab_rpt_zero", {k_rpt_valid, k_rpt_chan, k_rpt_data}, 0);
        check_eq("ab_inj_zero", {k_inj_valid, k_inj_data}, 0);
        check_eq("ab_fin_zero", {k_finish, k_code}, 0);
        rep_arr[0] = rep_arr[0] + 32'd1;
        tick();
        resetn   = 1'b1;
        k_events = 0;
        repeat (6) tick();
        check_eq("ab_no_events", k_events, 0);
        con_valid = 1'b1;
        con_data  = 8'h2E;
        repeat (2) tick();
        con_valid = 1'b0;
        repeat (8) tick();
        check_eq("ab_term_ignored", {k_finish, k_code}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
